burst_read_mode: RTL
====================

BURST_READ_MODE -- requirements
Module: burst_read_mode

Interface
REQ-001 Parameter: POLL_PERIOD, 24'd1000000, clk cycles between auto-poll frame starts; used only with RTC_AUTO_POLL_EN.
REQ-002 Parameter: CE_GAP, 4, minimum clk cycles ce stays low between frames.
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  active-high frame request, sampled only in IDLE.
REQ-006 ce  output  1  RTC chip enable.
REQ-007 sclk  output  1  RTC serial clock.
REQ-008 io_out  output  1  serial data driven to RTC, LSB first.
REQ-009 io_oe  output  1  1 = drive io pad with io_out; 0 = release pad.
REQ-010 io_in  input  1  serial data from RTC pad.
REQ-011 sec, min, hour, date, mon, day, year, ctrl  output  8 each  BCD registers as read from the RTC.
REQ-012 busy  output  1  high while a frame is in progress.
REQ-013 done  output  1  one-clk pulse when a frame completes and outputs update.

Function
REQ-014 States SHALL be IDLE, CMD, READ, GAP; encoding is free.
REQ-015 IDLE->CMD SHALL occur on the clk edge where start==1; start is ignored in every other state.
REQ-016 ce SHALL be 1 in CMD and READ and 0 in IDLE and GAP; busy SHALL equal 1 in CMD, READ and GAP.
REQ-017 Each bit SHALL last 4 clk (phase counter 0..3); sclk 0 in phases 0-1, 1 in phases 2-3; sclk is 0 outside CMD/READ.
REQ-018 CMD SHALL shift out 8'hBF LSB first (1,1,1,1,1,1,0,1); io_out changes only at phase 0; io_oe=1 throughout CMD.
REQ-019 READ SHALL last 64 bits (8 bytes); io_oe=0 throughout READ; io_in sampled at the clk entering phase 2 (sclk rising); bytes assembled LSB first.
REQ-020 Byte order SHALL be sec, min, hour, date, mon, day, year, ctrl.
REQ-021 Captured bytes SHALL be held in shadow registers; all eight outputs update together on the edge that ends READ, with done=1 for that single cycle.
REQ-022 Frame timing: start sampled at edge N -> ce=1 from N+1 -> done=1 in cycle N+288 (72 bits x 4 clk) -> ce=0 from that same edge.
REQ-023 GAP SHALL hold CE_GAP cycles then return to IDLE; a start held high re-launches on the first IDLE cycle.
REQ-024 Bit/byte counters SHALL wrap only at frame boundaries; no partial-frame update of outputs ever occurs.
REQ-025 io_out SHALL be 0 whenever io_oe=0.

Reset
REQ-026 rstn low SHALL immediately force: state IDLE, ce=0, sclk=0, io_out=0, io_oe=0, busy=0, done=0, all data outputs 8'h00, counters 0.
REQ-027 Reset mid-frame SHALL abort the frame with no output update; after release the block waits in IDLE for start.

Configuration
REQ-028 Macro RTC_AUTO_POLL_EN: when defined, a free-running POLL_PERIOD counter (running from reset release) SHALL request a frame at each expiry, ORed with start; an expiry during a frame is held pending and honoured at the next IDLE.
REQ-029 Without RTC_AUTO_POLL_EN, frames start only from start; no poll counter exists.

Verification
REQ-030 Reset: rstn low for 2 clk mid-READ -> all outputs zero within the same cycle, done never pulses.
REQ-031 Command: start pulse -> io_out sequence 1,1,1,1,1,1,0,1 with io_oe=1, one bit per 4 clk, sclk rising at phase 2.
REQ-032 Read: RTC model returns 45,30,12,25,12,03,24,80 (hex) on sclk falling -> sec=8'h45 ... ctrl=8'h80, done one cycle at start edge +288, io_oe=0 during READ.
REQ-033 Busy ignore: second start pulse at cycle +100 -> no restart, single done, outputs unchanged mid-frame.
REQ-034 Back-to-back: start held high -> ce low for exactly CE_GAP+1 clk between frames, second frame returns new model data.
REQ-035 RTC_AUTO_POLL_EN with POLL_PERIOD=500, start=0 -> frames start at cycles 500, 1000, 1500 after reset release.

Source files
------------

// File: rtl/burst_read_mode.sv
// Burst clock/calendar read from a serial RTC: command 8'hBF, then 8 bytes in, LSB first.
// Optional free-running auto-poll is compiled in with `define RTC_AUTO_POLL_EN.
module burst_read_mode #(
    parameter logic [23:0] POLL_PERIOD = 24'd1000000,
    parameter int          CE_GAP      = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    output logic       ce,
    output logic       sclk,
    output logic       io_out,
    output logic       io_oe,
    input  logic       io_in,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour,
    output logic [7:0] date,
    output logic [7:0] mon,
    output logic [7:0] day,
    output logic [7:0] year,
    output logic [7:0] ctrl,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] READ = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    localparam logic [7:0] CMD_BYTE = 8'hBF;
    localparam logic [7:0] GAP_LAST = 8'(CE_GAP - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [5:0]  bit_q,   bit_d;
    logic [7:0]  gap_q,   gap_d;
    logic [63:0] shift_q, shift_d;
    logic [63:0] data_q,  data_d;
    logic        done_q,  done_d;
    logic        req;

`ifdef RTC_AUTO_POLL_EN
    logic [23:0] poll_q, poll_d;
    logic        pend_q, pend_d;
    logic        expire;

    // An expiry seen outside IDLE is remembered until the next IDLE cycle consumes it.
    always_comb begin
        expire = (poll_q == POLL_PERIOD - 24'd1);
        poll_d = expire ? 24'd0 : poll_q + 24'd1;
        pend_d = (state_q == IDLE) ? 1'b0 : (pend_q | expire);
        req    = start | pend_q | expire;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            poll_q <= '0;
            pend_q <= 1'b0;
        end else begin
            poll_q <= poll_d;
            pend_q <= pend_d;
        end
    end
`else
    assign req = start;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = CMD;
                    phase_d = 2'd0;
                    bit_d   = 6'd0;
                end
            end
            CMD: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) begin
                    if (bit_q == 6'd7) begin
                        state_d = READ;
                        bit_d   = 6'd0;
                    end else begin
                        bit_d = bit_q + 6'd1;
                    end
                end
            end
            READ: begin
                phase_d = phase_q + 2'd1;
                // Sample on the edge that raises sclk; shifting right assembles bytes LSB first.
                if (phase_q == 2'd1) begin
                    shift_d = {io_in, shift_q[63:1]};
                end
                if (phase_q == 2'd3) begin
                    if (bit_q == 6'd63) begin
                        state_d = GAP;
                        bit_d   = 6'd0;
                        gap_d   = 8'd0;
                        data_d  = shift_q;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 6'd1;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            // NOTE: the shadow shift register is reset too, so no stale bits survive an aborted frame.
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // Pad-side outputs decode straight from registered state, so reset clears them at once.
    assign ce     = (state_q == CMD) || (state_q == READ);
    assign busy   = (state_q != IDLE);
    assign sclk   = ce & phase_q[1];
    assign io_oe  = (state_q == CMD);
    assign io_out = io_oe & CMD_BYTE[bit_q[2:0]];
    assign done   = done_q;

    assign sec  = data_q[7:0];
    assign min  = data_q[15:8];
    assign hour = data_q[23:16];
    assign date = data_q[31:24];
    assign mon  = data_q[39:32];
    assign day  = data_q[47:40];
    assign year = data_q[55:48];
    assign ctrl = data_q[63:56];

endmodule
